// File: rtl/ysyx_25070198_lsu_pkg.sv
// Shared types and codes for the extended load/store unit.
package ysyx_25070198_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLSIZE  = 2'd3;

    // Natural alignment: address must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = addr_lo[0];
            SZ_W:    is_misaligned = |addr_lo[1:0];
            default: is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25070198_lsu_ext_if.sv
// EXU request, WBU response and SimpleBus data-port signals of the LSU.
// slave = the LSU's view, master = the surrounding pipeline and bus.
interface ysyx_25070198_lsu_ext_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic [1:0]            resp_cause;
    logic                  lsu_reqValid;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_respValid;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, lsu_rdata, lsu_respValid,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, lsu_rdata, lsu_respValid,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
    );
endinterface

// File: rtl/ysyx_25070198_lsu_align.sv
// Byte-lane mask, store-data lane shift and load extraction/extension.
module ysyx_25070198_lsu_align
    import ysyx_25070198_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    size,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic                          is_unsigned,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W-1:0]             rdata,
    output logic [DATA_W/8-1:0]           wmask,
    output logic [DATA_W-1:0]             wdata_lane,
    output logic [DATA_W-1:0]             rdata_ext
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0]      base;
    logic [DATA_W-1:0]  bytesel;
    logic [DATA_W-1:0]  shifted;
    logic signed [7:0]  rd_b;
    logic signed [15:0] rd_h;
    logic signed [31:0] rd_w;

    always_comb begin
        base = '0;
        case (size)
            SZ_B:    base = NB'(1);
            SZ_H:    base = NB'(3);
            SZ_W:    base = NB'(15);
            default: base = '1;
        endcase

        bytesel = '0;
        for (int i = 0; i < NB; i++) begin
            bytesel[8*i +: 8] = {8{base[i]}};
        end

        wmask      = base << off;
        wdata_lane = (wdata & bytesel) << {off, 3'b000};

        // Bring the addressed lane down to bit 0, then extend by size.
        shifted = rdata >> {off, 3'b000};
        rd_b    = shifted[7:0];
        rd_h    = shifted[15:0];
        rd_w    = shifted[31:0];

        rdata_ext = shifted;
        case (size)
            SZ_B: begin
                if (is_unsigned) rdata_ext = DATA_W'(shifted[7:0]);
                else             rdata_ext = DATA_W'(rd_b);
            end
            SZ_H: begin
                if (is_unsigned) rdata_ext = DATA_W'(shifted[15:0]);
                else             rdata_ext = DATA_W'(rd_h);
            end
            SZ_W: begin
                if (is_unsigned) rdata_ext = DATA_W'(shifted[31:0]);
                else             rdata_ext = DATA_W'(rd_w);
            end
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25070198_lsu_ext.sv
// Load/store unit between EXU and the SimpleBus data port: latches one access,
// drives the bus, bounds latency with a timeout and returns data or an error.
module ysyx_25070198_lsu_ext
    import ysyx_25070198_lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_25070198_lsu_ext_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          size_p1;
    logic [OFF_W-1:0]    off_p1;
    logic                unsigned_p1;

    logic                lsu_reqvalid_r;
    logic [ADDR_W-1:0]   lsu_addr_r;
    logic                lsu_wen_r;
    logic [DATA_W-1:0]   lsu_wdata_r;
    logic [NB-1:0]       lsu_wmask_r;
    logic                resp_valid_r;
    logic [DATA_W-1:0]   resp_rdata_r;
    logic                resp_err_r;
    logic [1:0]          resp_cause_r;

    logic                accept;
    logic                illegal;
    logic                misalign;
    logic                timeout_hit;
    logic [1:0]          size_sel;
    logic [OFF_W-1:0]    off_sel;
    logic [NB-1:0]       al_wmask;
    logic [DATA_W-1:0]   al_wdata;
    logic [DATA_W-1:0]   al_rdata;

    assign accept   = bus.req_valid && (state == IDLE);
    assign illegal  = (DATA_W == 32) && (bus.req_size == SZ_D);
    assign misalign = is_misaligned(bus.req_addr[2:0], bus.req_size);
    // cnt holds the number of WAIT cycles already spent; this is the last one.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The aligner sees the live request in IDLE and the latched one afterwards.
    assign size_sel = (state == IDLE) ? bus.req_size : size_p1;
    assign off_sel  = (state == IDLE) ? bus.req_addr[OFF_W-1:0] : off_p1;

    ysyx_25070198_lsu_align #(.DATA_W(DATA_W)) u_align (
        .size        (size_sel),
        .off         (off_sel),
        .is_unsigned (unsigned_p1),
        .wdata       (bus.req_wdata),
        .rdata       (bus.lsu_rdata),
        .wmask       (al_wmask),
        .wdata_lane  (al_wdata),
        .rdata_ext   (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            size_p1        <= '0;
            off_p1         <= '0;
            unsigned_p1    <= 1'b0;
            lsu_reqvalid_r <= 1'b0;
            lsu_addr_r     <= '0;
            lsu_wen_r      <= 1'b0;
            lsu_wdata_r    <= '0;
            lsu_wmask_r    <= '0;
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= '0;
            resp_err_r     <= 1'b0;
            resp_cause_r   <= CAUSE_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_p1     <= bus.req_size;
                        off_p1      <= bus.req_addr[OFF_W-1:0];
                        unsigned_p1 <= bus.req_unsigned;
                        cnt         <= '0;
                        if (illegal || misalign) begin
                            state        <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                            resp_cause_r <= illegal ? CAUSE_ILLSIZE : CAUSE_MISALIGN;
                        end else begin
                            state          <= WAIT;
                            lsu_reqvalid_r <= 1'b1;
                            lsu_addr_r     <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            lsu_wen_r      <= bus.req_wen;
                            lsu_wdata_r    <= al_wdata;
                            lsu_wmask_r    <= al_wmask;
                        end
                    end
                end
                WAIT: begin
                    // A reply in the timeout cycle still counts as a success.
                    if (bus.lsu_respValid) begin
                        state          <= RESP;
                        lsu_reqvalid_r <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_err_r     <= 1'b0;
                        resp_cause_r   <= CAUSE_NONE;
                        resp_rdata_r   <= lsu_wen_r ? '0 : al_rdata;
                    end else if (timeout_hit) begin
                        state          <= RESP;
                        lsu_reqvalid_r <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_err_r     <= 1'b1;
                        resp_cause_r   <= CAUSE_TIMEOUT;
                        resp_rdata_r   <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_cause_r <= CAUSE_NONE;
                        resp_rdata_r <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.lsu_reqValid = lsu_reqvalid_r;
    assign bus.lsu_addr     = lsu_addr_r;
    assign bus.lsu_wen      = lsu_wen_r;
    assign bus.lsu_wdata    = lsu_wdata_r;
    assign bus.lsu_wmask    = lsu_wmask_r;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_rdata   = resp_rdata_r;
    assign bus.resp_err     = resp_err_r;
    assign bus.resp_cause   = resp_cause_r;

endmodule

// File: tb/tb_ysyx_25070198_lsu_ext.sv
// Directed bench: 32-bit LSU with a 4-cycle timeout and a 64-bit LSU.
module tb_ysyx_25070198_lsu_ext;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ysyx_25070198_lsu_ext_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
    ysyx_25070198_lsu_ext_if #(.DATA_W(64), .ADDR_W(32)) ifb ();

    ysyx_25070198_lsu_ext #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    ysyx_25070198_lsu_ext #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        ifa.req_wen      = wen;
        ifa.req_addr     = addr;
        ifa.req_wdata    = wdata;
        ifa.req_size     = size;
        ifa.req_unsigned = uns;
        ifa.req_valid    = 1'b1;
    endtask

    task automatic req_b(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns);
        ifb.req_wen      = wen;
        ifb.req_addr     = addr;
        ifb.req_wdata    = wdata;
        ifb.req_size     = size;
        ifb.req_unsigned = uns;
        ifb.req_valid    = 1'b1;
    endtask

    task automatic reply_a(input logic [31:0] data);
        ifa.lsu_rdata     = data;
        ifa.lsu_respValid = 1'b1;
        step();
        ifa.lsu_respValid = 1'b0;
    endtask

    task automatic reply_b(input logic [63:0] data);
        ifb.lsu_rdata     = data;
        ifb.lsu_respValid = 1'b1;
        step();
        ifb.lsu_respValid = 1'b0;
    endtask

    task automatic release_a();
        ifa.resp_ready = 1'b1;
        step();
        ifa.resp_ready = 1'b0;
    endtask

    task automatic release_b();
        ifb.resp_ready = 1'b1;
        step();
        ifb.resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_wen = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifa.req_size = 2'd0; ifa.req_unsigned = 1'b0; ifa.resp_ready = 1'b0;
        ifa.lsu_rdata = '0; ifa.lsu_respValid = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_wen = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.req_size = 2'd0; ifb.req_unsigned = 1'b0; ifb.resp_ready = 1'b0;
        ifb.lsu_rdata = '0; ifb.lsu_respValid = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_reqValid",   64'(ifa.lsu_reqValid), 64'd0);
        chk("rst_addr",       64'(ifa.lsu_addr), 64'd0);
        chk("rst_wmask",      64'(ifa.lsu_wmask), 64'd0);
        chk("rst_wdata",      64'(ifa.lsu_wdata), 64'd0);
        chk("rst_resp_valid", 64'(ifa.resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(ifa.resp_rdata), 64'd0);
        chk("rst_resp_err",   64'(ifa.resp_err), 64'd0);
        chk("rst_resp_cause", 64'(ifa.resp_cause), 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 64'(ifa.req_ready), 64'd1);

        // SB 0x80000003 <- 0xAB
        req_a(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("sb_reqValid", 64'(ifa.lsu_reqValid), 64'd1);
        chk("sb_addr",     64'(ifa.lsu_addr), 64'h8000_0000);
        chk("sb_wmask",    64'(ifa.lsu_wmask), 64'h8);
        chk("sb_wdata",    64'(ifa.lsu_wdata), 64'hAB00_0000);
        chk("sb_wen",      64'(ifa.lsu_wen), 64'd1);
        chk("sb_busy",     64'(ifa.req_ready), 64'd0);
        step();
        chk("sb_no_resp_yet", 64'(ifa.resp_valid), 64'd0);
        chk("sb_bus_held",    64'(ifa.lsu_wdata), 64'hAB00_0000);
        reply_a(32'hDEAD_BEEF);
        chk("sb_resp_valid", 64'(ifa.resp_valid), 64'd1);
        chk("sb_resp_err",   64'(ifa.resp_err), 64'd0);
        chk("sb_resp_rdata", 64'(ifa.resp_rdata), 64'd0);
        chk("sb_bus_drop",   64'(ifa.lsu_reqValid), 64'd0);
        release_a();
        chk("sb_resp_clear", 64'(ifa.resp_valid), 64'd0);
        chk("sb_ready_back", 64'(ifa.req_ready), 64'd1);

        // SH 0x80000002 <- 0x1234ABCD keeps only the low half
        req_a(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("sh_wmask", 64'(ifa.lsu_wmask), 64'hC);
        chk("sh_wdata", 64'(ifa.lsu_wdata), 64'hABCD_0000);
        reply_a(32'h0);
        release_a();

        // LH signed, then hold resp_ready low for 5 cycles
        req_a(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("lh_wmask", 64'(ifa.lsu_wmask), 64'hC);
        chk("lh_wen",   64'(ifa.lsu_wen), 64'd0);
        reply_a(32'h8001_1234);
        chk("lh_rdata", 64'(ifa.resp_rdata), 64'hFFFF_8001);
        req_a(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid",    64'(ifa.resp_valid), 64'd1);
            chk("hold_rdata",    64'(ifa.resp_rdata), 64'hFFFF_8001);
            chk("hold_ready",    64'(ifa.req_ready), 64'd0);
            chk("hold_reqValid", 64'(ifa.lsu_reqValid), 64'd0);
        end
        ifa.req_valid = 1'b0;
        release_a();

        // LHU same access
        req_a(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1);
        step();
        ifa.req_valid = 1'b0;
        reply_a(32'h8001_1234);
        chk("lhu_rdata", 64'(ifa.resp_rdata), 64'h0000_8001);
        release_a();

        // LB signed from lane 1
        req_a(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("lb_wmask", 64'(ifa.lsu_wmask), 64'h2);
        reply_a(32'h1234_F678);
        chk("lb_rdata", 64'(ifa.resp_rdata), 64'hFFFF_FFF6);
        release_a();

        // LW misaligned: error one cycle after acceptance, no bus request
        req_a(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("mis_valid",    64'(ifa.resp_valid), 64'd1);
        chk("mis_err",      64'(ifa.resp_err), 64'd1);
        chk("mis_cause",    64'(ifa.resp_cause), 64'd1);
        chk("mis_rdata",    64'(ifa.resp_rdata), 64'd0);
        chk("mis_reqValid", 64'(ifa.lsu_reqValid), 64'd0);
        release_a();
        chk("mis_reqValid_after", 64'(ifa.lsu_reqValid), 64'd0);

        // Dword on a 32-bit unit is an illegal size
        req_a(1'b0, 32'h8000_0008, 32'h0, 2'd3, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("ill_err",      64'(ifa.resp_err), 64'd1);
        chk("ill_cause",    64'(ifa.resp_cause), 64'd3);
        chk("ill_reqValid", 64'(ifa.lsu_reqValid), 64'd0);
        release_a();

        // Timeout after 4 WAIT cycles, then a late reply is ignored
        req_a(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_waiting",  64'(ifa.resp_valid), 64'd0);
            chk("to_bus_busy", 64'(ifa.lsu_reqValid), 64'd1);
        end
        step();
        chk("to_valid",    64'(ifa.resp_valid), 64'd1);
        chk("to_err",      64'(ifa.resp_err), 64'd1);
        chk("to_cause",    64'(ifa.resp_cause), 64'd2);
        chk("to_rdata",    64'(ifa.resp_rdata), 64'd0);
        chk("to_reqValid", 64'(ifa.lsu_reqValid), 64'd0);
        release_a();
        reply_a(32'h5555_AAAA);
        chk("late_no_resp", 64'(ifa.resp_valid), 64'd0);
        step();
        chk("late_no_resp2", 64'(ifa.resp_valid), 64'd0);
        chk("late_ready",    64'(ifa.req_ready), 64'd1);

        // Reply in the timeout cycle wins
        req_a(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        step(); step(); step();
        reply_a(32'hCAFE_F00D);
        chk("tie_valid", 64'(ifa.resp_valid), 64'd1);
        chk("tie_err",   64'(ifa.resp_err), 64'd0);
        chk("tie_cause", 64'(ifa.resp_cause), 64'd0);
        chk("tie_rdata", 64'(ifa.resp_rdata), 64'hCAFE_F00D);
        release_a();

        // Asynchronous reset during WAIT
        req_a(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        step();
        ifa.req_valid = 1'b0;
        chk("rstw_busy", 64'(ifa.lsu_reqValid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_reqValid", 64'(ifa.lsu_reqValid), 64'd0);
        chk("rstw_addr",     64'(ifa.lsu_addr), 64'd0);
        chk("rstw_wmask",    64'(ifa.lsu_wmask), 64'd0);
        chk("rstw_valid",    64'(ifa.resp_valid), 64'd0);
        #1 rst = 1'b0;
        step();
        chk("rstw_ready", 64'(ifa.req_ready), 64'd1);
        reply_a(32'hFFFF_FFFF);
        chk("rstw_stale_reply", 64'(ifa.resp_valid), 64'd0);
        req_a(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b1);
        step();
        ifa.req_valid = 1'b0;
        chk("post_rst_reqValid", 64'(ifa.lsu_reqValid), 64'd1);
        reply_a(32'h1234_5678);
        chk("post_rst_lbu", 64'(ifa.resp_rdata), 64'h0000_0056);
        release_a();

        // 64-bit unit: LD at 0x8 and signed LW from the upper word
        req_b(1'b0, 32'h0000_0008, 64'h0, 2'd3, 1'b0);
        step();
        ifb.req_valid = 1'b0;
        chk("ld_wmask", 64'(ifb.lsu_wmask), 64'hFF);
        chk("ld_addr",  64'(ifb.lsu_addr), 64'h8);
        reply_b(64'hFEDC_BA98_7654_3210);
        chk("ld_err",   64'(ifb.resp_err), 64'd0);
        chk("ld_rdata", ifb.resp_rdata, 64'hFEDC_BA98_7654_3210);
        release_b();
        req_b(1'b0, 32'h0000_000C, 64'h0, 2'd2, 1'b0);
        step();
        ifb.req_valid = 1'b0;
        chk("lw64_wmask", 64'(ifb.lsu_wmask), 64'hF0);
        chk("lw64_addr",  64'(ifb.lsu_addr), 64'h8);
        reply_b(64'h8000_0001_0000_0000);
        chk("lw64_rdata", ifb.resp_rdata, 64'hFFFF_FFFF_8000_0001);
        release_b();
        req_b(1'b1, 32'h0000_0010, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
        step();
        ifb.req_valid = 1'b0;
        chk("sd_wdata", ifb.lsu_wdata, 64'h1122_3344_5566_7788);
        chk("sd_wmask", 64'(ifb.lsu_wmask), 64'hFF);
        reply_b(64'h0);
        release_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
